// File: rtl/stream_prefetcher.sv
// Multi-stream sequential prefetcher: trains ascending/descending streams on the
// miss path and offers up to DEGREE line prefetches ahead of each demand pointer.
module stream_prefetcher #(
    parameter int LINE_WIDTH  = 256,
    parameter int NUM_STREAMS = 4,
    parameter int DEGREE      = 2,
    parameter int PAGE_BITS   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pf_enable,
    input  logic        ms_valid,
    input  logic [31:0] ms_addr,
    input  logic        rq_valid,
    input  logic [31:0] rq_addr,
    output logic        pf_valid,
    output logic [31:0] pf_addr,
    input  logic        pf_answer
);
    localparam int                  LINE_BYTES = LINE_WIDTH / 8;
    localparam int                  IDX_BITS   = $clog2(NUM_STREAMS);
    localparam logic [31:0]         LINE_STEP  = 32'(LINE_BYTES);
    localparam logic [31:0]         LINE_MASK  = ~(LINE_STEP - 32'd1);
    localparam logic [3:0]          DEG        = 4'(DEGREE);
    localparam logic [IDX_BITS-1:0] LRU_RANK   = '1;

    typedef struct packed {
        logic                valid;
        logic                active;
        logic                dir_neg;
        logic [31:0]         last_line;
        logic [31:0]         next_pf;
        logic [3:0]          ahead;
        logic [IDX_BITS-1:0] rank;
    } entry_t;

    entry_t ent_q [NUM_STREAMS];
    entry_t ent_d [NUM_STREAMS];
    logic [IDX_BITS-1:0] gnt_q;

    logic [31:0]         ev_line, new_last;
    logic                hit_cons, hit_train, train_neg, found_free;
    logic                do_cons, do_train, do_alloc, touch, answered, cancel, any_elig;
    logic [IDX_BITS-1:0] cons_idx, train_idx, free_idx, lru_idx, touch_idx, gnt_d;
    logic [NUM_STREAMS-1:0] elig;

    function automatic logic [31:0] line_step(input logic [31:0] line, input logic neg);
        return neg ? line - LINE_STEP : line + LINE_STEP;
    endfunction

    // Event decode: consume beats train beats allocate, lowest index wins within each.
    always_comb begin
        ev_line    = (ms_valid ? ms_addr : rq_addr) & LINE_MASK;
        hit_cons   = 1'b0;
        cons_idx   = '0;
        hit_train  = 1'b0;
        train_idx  = '0;
        train_neg  = 1'b0;
        found_free = 1'b0;
        free_idx   = '0;
        lru_idx    = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].active &&
                ev_line == line_step(ent_q[i].last_line, ent_q[i].dir_neg)) begin
                hit_cons = 1'b1;
                cons_idx = IDX_BITS'(i);
            end
            if (ent_q[i].valid && !ent_q[i].active &&
                (ev_line == line_step(ent_q[i].last_line, 1'b0) ||
                 ev_line == line_step(ent_q[i].last_line, 1'b1))) begin
                hit_train = 1'b1;
                train_idx = IDX_BITS'(i);
                train_neg = (ev_line == line_step(ent_q[i].last_line, 1'b1));
            end
            if (!ent_q[i].valid) begin
                found_free = 1'b1;
                free_idx   = IDX_BITS'(i);
            end
            if (ent_q[i].rank == LRU_RANK) lru_idx = IDX_BITS'(i);
        end
        do_cons   = (ms_valid | rq_valid) & hit_cons;
        do_train  = ms_valid & ~hit_cons & hit_train;
        do_alloc  = ms_valid & ~hit_cons & ~hit_train;
        touch     = do_cons | do_train | do_alloc;
        touch_idx = do_cons ? cons_idx : (do_train ? train_idx : (found_free ? free_idx : lru_idx));
        answered  = pf_valid & pf_answer;
        cancel    = pf_valid & ~pf_answer & (do_train | do_alloc) & (touch_idx == gnt_q);
    end

    // Next entry state; rank 0 is MRU, ranks stay a permutation of 0..NUM_STREAMS-1.
    always_comb begin
        new_last = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            ent_d[i] = ent_q[i];
            if (touch) begin
                if (touch_idx == IDX_BITS'(i))
                    ent_d[i].rank = '0;
                else if (ent_q[i].rank < ent_q[touch_idx].rank)
                    ent_d[i].rank = ent_q[i].rank + IDX_BITS'(1);
            end
            if (do_alloc && touch_idx == IDX_BITS'(i)) begin
                ent_d[i].valid     = 1'b1;
                ent_d[i].active    = 1'b0;
                ent_d[i].dir_neg   = 1'b0;
                ent_d[i].last_line = ev_line;
                ent_d[i].next_pf   = ev_line;
                ent_d[i].ahead     = '0;
            end else if (do_train && touch_idx == IDX_BITS'(i)) begin
                ent_d[i].active    = 1'b1;
                ent_d[i].dir_neg   = train_neg;
                ent_d[i].last_line = ev_line;
                ent_d[i].next_pf   = line_step(ev_line, train_neg);
                ent_d[i].ahead     = '0;
            end else begin
                new_last = line_step(ent_q[i].last_line, ent_q[i].dir_neg);
                if (do_cons && cons_idx == IDX_BITS'(i)) begin
                    ent_d[i].last_line = new_last;
                    if (ent_q[i].ahead == 4'd0)
                        ent_d[i].next_pf = line_step(new_last, ent_q[i].dir_neg);
                    else if (answered && gnt_q == IDX_BITS'(i))
                        ent_d[i].next_pf = line_step(ent_q[i].next_pf, ent_q[i].dir_neg);
                    else
                        ent_d[i].ahead = ent_q[i].ahead - 4'd1;
                end else if (answered && gnt_q == IDX_BITS'(i)) begin
                    ent_d[i].next_pf = line_step(ent_q[i].next_pf, ent_q[i].dir_neg);
                    ent_d[i].ahead   = ent_q[i].ahead + 4'd1;
                end
            end
        end
    end

    always_comb begin
        elig     = '0;
        any_elig = 1'b0;
        gnt_d    = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            elig[i] = pf_enable && ent_d[i].valid && ent_d[i].active && (ent_d[i].ahead < DEG) &&
                      (ent_d[i].next_pf[31:PAGE_BITS] == ent_d[i].last_line[31:PAGE_BITS]);
            if (elig[i]) begin
                any_elig = 1'b1;
                gnt_d    = IDX_BITS'(i);
            end
        end
    end

    // Handshake: pf_valid/pf_addr are registers. Once pf_valid is high without
    // pf_answer the offer is locked and pf_addr holds; pf_valid && pf_answer in a
    // cycle completes the transfer, and a fresh grant may appear the next cycle.
    // Reallocating or retraining the locked entry withdraws the offer instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                ent_q[i].valid     <= 1'b0;
                ent_q[i].active    <= 1'b0;
                ent_q[i].dir_neg   <= 1'b0;
                ent_q[i].last_line <= '0;
                ent_q[i].next_pf   <= '0;
                ent_q[i].ahead     <= '0;
                ent_q[i].rank      <= IDX_BITS'(i);
            end
            pf_valid <= 1'b0;
            pf_addr  <= '0;
            gnt_q    <= '0;
        end else begin
            ent_q <= ent_d;
            if (pf_valid && !pf_answer) begin
                if (cancel) pf_valid <= 1'b0;
            end else begin
                pf_valid <= any_elig;
                if (any_elig) begin
                    pf_addr <= ent_d[gnt_d].next_pf;
                    gnt_q   <= gnt_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_prefetcher.sv
// Directed bench for stream_prefetcher: a stream-level model checked every cycle,
// an accepted-prefetch scoreboard, and hand-computed literal expectations.
module tb_stream_prefetcher;
    localparam int LB  = 32;
    localparam int NS  = 4;
    localparam int DEG = 2;
    localparam int PB  = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pf_enable = 1'b1;
    logic        ms_valid = 1'b0;
    logic [31:0] ms_addr = '0;
    logic        rq_valid = 1'b0;
    logic [31:0] rq_addr = '0;
    logic        pf_answer = 1'b0;
    logic        pf_valid;
    logic [31:0] pf_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    stream_prefetcher #(.LINE_WIDTH(256), .NUM_STREAMS(NS), .DEGREE(DEG), .PAGE_BITS(PB)) dut (
        .clk(clk), .reset(reset), .pf_enable(pf_enable),
        .ms_valid(ms_valid), .ms_addr(ms_addr),
        .rq_valid(rq_valid), .rq_addr(rq_addr),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_answer(pf_answer)
    );

    always #5 clk = ~clk;

    // ---------------- stream model ----------------
    bit          m_valid  [NS];
    bit          m_active [NS];
    int          m_dir    [NS];
    logic [31:0] m_last   [NS];
    logic [31:0] m_next   [NS];
    int          m_ahead  [NS];
    int          lru_q[$];
    bit          m_pfv;
    logic [31:0] m_pfa;
    int          m_g;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] stepl(input logic [31:0] a, input int d);
        return a + 32'(d * LB);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 1'b0; m_active[i] = 1'b0; m_dir[i] = 1;
            m_last[i] = '0; m_next[i] = '0; m_ahead[i] = 0;
        end
        lru_q.delete();
        for (int i = 0; i < NS; i++) lru_q.push_back(i);
        exp_q.delete();
        m_pfv = 1'b0; m_pfa = '0; m_g = 0;
    endtask

    task automatic model_step();
        logic [31:0] line;
        int hit, kind, tdir;
        bit acc, cancel;
        acc = m_pfv && pf_answer;
        if (acc) exp_q.push_back(m_pfa);
        hit = -1; kind = 0; tdir = 1; line = '0;
        if (ms_valid || rq_valid) begin
            line = (ms_valid ? ms_addr : rq_addr) & ~32'(LB - 1);
            for (int i = 0; i < NS; i++)
                if (hit < 0 && m_valid[i] && m_active[i] && line == stepl(m_last[i], m_dir[i])) begin
                    hit = i; kind = 1;
                end
            if (ms_valid && hit < 0)
                for (int i = 0; i < NS; i++)
                    if (hit < 0 && m_valid[i] && !m_active[i]) begin
                        if (line == stepl(m_last[i], 1)) begin hit = i; kind = 2; tdir = 1; end
                        else if (line == stepl(m_last[i], -1)) begin hit = i; kind = 2; tdir = -1; end
                    end
            if (ms_valid && hit < 0) begin
                kind = 3;
                for (int i = 0; i < NS; i++) if (hit < 0 && !m_valid[i]) hit = i;
                if (hit < 0) hit = lru_q[$];
            end
        end
        cancel = m_pfv && !pf_answer && kind >= 2 && hit == m_g;
        if (kind == 3) begin
            m_valid[hit] = 1'b1; m_active[hit] = 1'b0; m_last[hit] = line; m_ahead[hit] = 0;
        end else if (kind == 2) begin
            m_active[hit] = 1'b1; m_dir[hit] = tdir; m_last[hit] = line;
            m_next[hit] = stepl(line, tdir); m_ahead[hit] = 0;
        end else if (kind == 1) begin
            m_last[hit] = stepl(m_last[hit], m_dir[hit]);
            if (acc && m_g == hit) begin
                if (m_ahead[hit] == 0) m_next[hit] = stepl(m_last[hit], m_dir[hit]);
                else m_next[hit] = stepl(m_next[hit], m_dir[hit]);
            end else if (m_ahead[hit] > 0) m_ahead[hit]--;
            else m_next[hit] = stepl(m_last[hit], m_dir[hit]);
        end
        if (acc && !(kind != 0 && hit == m_g)) begin
            m_next[m_g] = stepl(m_next[m_g], m_dir[m_g]);
            m_ahead[m_g]++;
        end
        if (kind != 0) begin
            for (int k = 0; k < lru_q.size(); k++)
                if (lru_q[k] == hit) begin lru_q.delete(k); break; end
            lru_q.push_front(hit);
        end
        if (m_pfv && !pf_answer) begin
            if (cancel) m_pfv = 1'b0;
        end else begin
            m_pfv = 1'b0;
            for (int i = 0; i < NS; i++)
                if (!m_pfv && pf_enable && m_valid[i] && m_active[i] && m_ahead[i] < DEG &&
                    m_next[i][31:PB] == m_last[i][31:PB]) begin
                    m_pfv = 1'b1; m_pfa = m_next[i]; m_g = i;
                end
        end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit          offer_v = 1'b0;
    logic [31:0] offer_a = '0;

    always @(negedge clk) begin
        offer_v = pf_valid;
        offer_a = pf_addr;
        if (chk_en) begin
            check("cyc_pf_valid", {31'd0, pf_valid}, {31'd0, m_pfv});
            if (m_pfv) check("cyc_pf_addr", pf_addr, m_pfa);
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !reset && offer_v && pf_answer) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept: got %h with no accept expected at %0t", offer_a, $time);
            end else begin
                check("accept", offer_a, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit msv, input logic [31:0] msa, input bit rqv,
                       input logic [31:0] rqa, input bit ans);
        ms_valid = msv; ms_addr = msa; rq_valid = rqv; rq_addr = rqa; pf_answer = ans;
        @(negedge clk);
    endtask

    task automatic miss(input logic [31:0] a, input bit ans);
        cyc(1'b1, a, 1'b0, 32'd0, ans);
    endtask

    task automatic req(input logic [31:0] a, input bit ans);
        cyc(1'b0, 32'd0, 1'b1, a, ans);
    endtask

    task automatic idle(input bit ans);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, ans);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_pf_valid", {31'd0, pf_valid}, 32'd0);
        check("reset_pf_addr", pf_addr, 32'd0);
    endtask

    task automatic lit_v(input string name, input bit v, input logic [31:0] a);
        check({name, "_valid"}, {31'd0, pf_valid}, {31'd0, v});
        if (v) check({name, "_addr"}, pf_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Ascending stream with answers tied high.
        do_reset();
        miss(32'h1000, 1'b1);  lit_v("asc_train0", 1'b0, 32'h0);
        miss(32'h1020, 1'b1);  lit_v("asc_pf0", 1'b1, 32'h1040);
        idle(1'b1);            lit_v("asc_pf1", 1'b1, 32'h1060);
        idle(1'b1);            lit_v("asc_full", 1'b0, 32'h0);
        req(32'h1040, 1'b1);   lit_v("asc_rq_pf", 1'b1, 32'h1080);
        idle(1'b1);            lit_v("asc_full2", 1'b0, 32'h0);
        req(32'h7000, 1'b1);   lit_v("asc_rq_nomatch", 1'b0, 32'h0);

        // Descending stream.
        do_reset();
        miss(32'h2100, 1'b1);
        miss(32'h20E0, 1'b1);  lit_v("desc_pf0", 1'b1, 32'h20C0);
        idle(1'b1);            lit_v("desc_pf1", 1'b1, 32'h20A0);
        idle(1'b1);            lit_v("desc_full", 1'b0, 32'h0);

        // Page boundary, then continuing in the new page; consume + answer together.
        do_reset();
        miss(32'h1FC0, 1'b1);
        miss(32'h1FE0, 1'b1);  lit_v("page_block", 1'b0, 32'h0);
        idle(1'b1);            lit_v("page_block2", 1'b0, 32'h0);
        miss(32'h2000, 1'b1);  lit_v("page_new", 1'b1, 32'h2020);
        miss(32'h2020, 1'b1);  lit_v("page_cons_ans", 1'b1, 32'h2040);
        idle(1'b1);
        idle(1'b1);            lit_v("page_full", 1'b0, 32'h0);
        // 32-bit wrap leaves the page; a miss at line 0 resumes.
        miss(32'hFFFF_FFC0, 1'b1);
        miss(32'hFFFF_FFE0, 1'b1); lit_v("wrap_block", 1'b0, 32'h0);
        miss(32'h0000_0000, 1'b1); lit_v("wrap_resume", 1'b1, 32'h0000_0020);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: lock holds while a lower-index stream becomes eligible.
        do_reset();
        miss(32'h5000, 1'b0);
        miss(32'h8000, 1'b0);
        miss(32'h8020, 1'b0);  lit_v("bp_first", 1'b1, 32'h8040);
        miss(32'h5020, 1'b0);  lit_v("bp_hold0", 1'b1, 32'h8040);
        for (int k = 1; k < 5; k++) begin
            idle(1'b0);        lit_v("bp_hold", 1'b1, 32'h8040);
        end
        idle(1'b1);            lit_v("bp_low_gnt", 1'b1, 32'h5040);
        idle(1'b1);
        idle(1'b1);

        // Replacement with cancel of the locked entry, twice to exercise LRU order.
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            miss(32'(s) << 16, 1'b0);
            miss((32'(s) << 16) + 32'h20, 1'b0);
        end
        lit_v("rep_locked", 1'b1, 32'h1_0040);
        miss(32'h9_0000, 1'b0); lit_v("rep_cancel0", 1'b0, 32'h0);
        idle(1'b0);             lit_v("rep_regrant0", 1'b1, 32'h2_0040);
        miss(32'hA_0000, 1'b0); lit_v("rep_cancel1", 1'b0, 32'h0);
        idle(1'b0);             lit_v("rep_regrant1", 1'b1, 32'h3_0040);

        // Reset while an offer is pending, then a lone miss.
        reset = 1'b1;
        idle(1'b0);
        check("rst_mid_valid", {31'd0, pf_valid}, 32'd0);
        check("rst_mid_addr", pf_addr, 32'd0);
        reset = 1'b0;
        miss(32'h5_0000, 1'b1);
        idle(1'b1);             lit_v("rst_single_miss", 1'b0, 32'h0);

        // pf_enable gating: training proceeds, grant waits for enable.
        do_reset();
        pf_enable = 1'b0;
        miss(32'h6000, 1'b1);
        miss(32'h6020, 1'b1);   lit_v("en_off", 1'b0, 32'h0);
        idle(1'b1);             lit_v("en_off2", 1'b0, 32'h0);
        pf_enable = 1'b1;
        idle(1'b1);             lit_v("en_on", 1'b1, 32'h6040);
        idle(1'b1);
        idle(1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
